// File: rtl/serial_sub_unit.sv
// Digit-serial subtractor: computes x - y - borrow_in over WIDTH/DIGIT clocks, LSB digit first,
// with a start/busy/done handshake and registered unsigned-borrow and signed-overflow flags.
module serial_sub_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              x_msb_q, x_msb_d;
  logic              y_msb_q, y_msb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig_x, dig_y, dig_d;
  logic                   dig_b;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   last_step;

  assign dig_x     = x_q[DIGIT-1:0];
  assign dig_y     = y_q[DIGIT-1:0];
  assign last_step = (cnt_q == CntW'(STEPS - 1));

  // One digit of the ripple: borrow out of the digit lands in the extra MSB.
  always_comb begin
    {dig_b, dig_d} = {1'b0, dig_x} - {1'b0, dig_y} - {{DIGIT{1'b0}}, borrow_q};
    res_cat        = {dig_d, res_q} >> DIGIT;
    res_shift      = res_cat[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    x_msb_d  = x_msb_q;
    y_msb_d  = y_msb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          x_d      = x_in;
          y_d      = y_in;
          borrow_d = borrow_in;
          x_msb_d  = x_in[WIDTH-1];
          y_msb_d  = y_in[WIDTH-1];
          res_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        x_d      = x_q >> DIGIT;
        y_d      = y_q >> DIGIT;
        res_d    = res_shift;
        borrow_d = dig_b;
        cnt_d    = cnt_q + CntW'(1);
        if (last_step) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = res_shift;
          bout_d  = dig_b;
          // Overflow only possible when operand signs differ; judged on the captured signs.
          ovf_d   = (x_msb_q != y_msb_q) && (res_shift[WIDTH-1] != x_msb_q);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      x_msb_q  <= 1'b0;
      y_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      x_msb_q  <= x_msb_d;
      y_msb_q  <= y_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign difference = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;

endmodule
